// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice processes WIDTH bit pairs, LSB first,
// with a registered carry loop; the result is presented with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;

    full_adder_v u_fa (
        .C    (c_reg),
        .B    (b_sh[0]),
        .A    (a_sh[0]),
        .S    (fa_s),
        .COUT (fa_cout)
    );

    // Last bit's S must reach sum in the same edge, so sum loads the shifted value.
    assign res_next = {fa_s, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            c_reg  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        c_reg  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    c_reg  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// One-bit full-adder cell.
module full_adder_v (
    input  logic C,
    input  logic B,
    input  logic A,
    output logic S,
    output logic COUT
);
    assign S    = A ^ B ^ C;
    assign COUT = (A & B) | (C & (A ^ B));
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: 8-bit and 4-bit instances checked every cycle
// against a transaction-level timing/arithmetic model plus directed literal checks.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: accept edge k in idle; busy after edges k..k+W-1, done after k+W,
    // result latched at k+W, next acceptance possible from edge k+W+2.
    int     edge_n = 0;
    int     acc[2] = '{-1, -1};
    int     wid[2] = '{8, 4};
    longint pend[2];
    longint ex_sum[2] = '{0, 0};
    longint ex_cout[2] = '{0, 0};
    bit     st[2];
    longint tot[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                acc[i] = -1;
                ex_sum[i] = 0;
                ex_cout[i] = 0;
            end
        end else begin
            edge_n++;
            st[0]  = start8;
            st[1]  = start4;
            tot[0] = longint'(a8) + longint'(b8) + longint'(cin8);
            tot[1] = longint'(a4) + longint'(b4) + longint'(cin4);
            for (int i = 0; i < 2; i++) begin
                if (st[i] && (acc[i] < 0 || edge_n >= acc[i] + wid[i] + 2)) begin
                    acc[i]  = edge_n;
                    pend[i] = tot[i];
                end else if (acc[i] >= 0 && edge_n == acc[i] + wid[i]) begin
                    ex_sum[i]  = pend[i] % (longint'(1) << wid[i]);
                    ex_cout[i] = (pend[i] >> wid[i]) & 1;
                end
            end
        end
    end

    function automatic logic exp_busy(input int i);
        return acc[i] >= 0 && edge_n >= acc[i] && edge_n < acc[i] + wid[i];
    endfunction

    function automatic logic exp_done(input int i);
        return acc[i] >= 0 && edge_n == acc[i] + wid[i];
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("busy8", 64'(busy8), 64'(exp_busy(0)));
            chk("done8", 64'(done8), 64'(exp_done(0)));
            chk("sum8",  64'(sum8),  64'(ex_sum[0]));
            chk("cout8", 64'(cout8), 64'(ex_cout[0]));
            chk("busy4", 64'(busy4), 64'(exp_busy(1)));
            chk("done4", 64'(done4), 64'(exp_done(1)));
            chk("sum4",  64'(sum4),  64'(ex_sum[1]));
            chk("cout4", 64'(cout4), 64'(ex_cout[1]));
        end
    end

    task automatic wait_done8(output bit seen, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            nbusy += int'(busy8);
        end while (!done8 && n < 40);
        seen = done8;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input string nm);
        bit seen;
        int n, nb;
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
        n = 1;
        nb = int'(busy8);
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
            nb += int'(busy8);
        end
        seen = done8;
        chk({nm, "_seen"}, 64'(seen), 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'd9);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'd8);
        chk({nm, "_sum"}, 64'(sum8), 64'(es));
        chk({nm, "_cout"}, 64'(cout8), 64'(ec));
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [4:0] ex, input string nm);
        int n;
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'd5);
        chk({nm, "_result"}, 64'({cout4, sum4}), 64'(ex));
    endtask

    initial begin
        bit seen;
        int n, nb, dones;
        logic [7:0] s1;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_sum",  64'({cout8, sum8}), 64'd0);

        // Basic, full carry propagation
        op8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "t1_5a_33");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2_ff_01");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2_ff_ff_c1");

        // Starts during RUN and DONE are ignored
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        s1 = '0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (done8) begin
                dones++;
                s1 = sum8;
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        chk("t3_single_done", 64'(dones), 64'd1);
        chk("t3_sum", 64'(s1), 64'h46);
        chk("t3_cout", 64'(cout8), 64'd0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", 64'(busy8), 64'd0);
        chk("t4_rst_sum", 64'(sum8), 64'd0);
        chk("t4_rst_cout", 64'(cout8), 64'd0);
        #4 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chk("t4_no_done", 64'(dones), 64'd0);
        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "t4_fresh");

        // Back-to-back with start held high
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        wait_done8(seen, n, nb);
        chk("t5_first_seen", 64'(seen), 64'd1);
        chk("t5_first_lat", 64'(n), 64'd9);
        chk("t5_first_sum", 64'(sum8), 64'h03);
        a8 = 8'h10; b8 = 8'h20;
        wait_done8(seen, n, nb);
        start8 = 1'b0;
        chk("t5_second_seen", 64'(seen), 64'd1);
        chk("t5_spacing", 64'(n), 64'd10);
        chk("t5_second_sum", 64'(sum8), 64'h30);
        repeat (15) @(negedge clk);

        // WIDTH=4 literals then exhaustive sweep
        op4(4'hF, 4'hF, 1'b1, 5'h1F, "w4_f_f_1");
        op4(4'h9, 4'h8, 1'b0, 5'h11, "w4_9_8_0");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c), 5'(a + b + c), "w4_exh");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL timeout: got no completion expected completion before 1ms");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder stage built around the team's one-bit full-adder cell, full_adder_v (ports C, B, A, S, COUT).
- Accepts two WIDTH-bit operands and a carry-in on a start strobe.
- Drives the cell with one bit pair per clock, LSB first, through a registered carry loop.
- Collects S into a result shift register and presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between operand-producing logic and any consumer of the sum. It trades WIDTH cycles of latency for a single full-adder slice.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2 to 32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE.
a_in  input  WIDTH  operand A; captured on an accepted start.
b_in  input  WIDTH  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse; sum and cout are valid.
sum  output  WIDTH  registered result (A+B+cin) mod 2^WIDTH.
cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset (asynchronous, active-high, clk not required):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and bit counter all = 0.
- States: IDLE, RUN, DONE. Encoding is free; no illegal-state lockup (unused codes go to IDLE).
- IDLE:
  - On start=1 at edge k: load a_sh<=a_in, b_sh<=b_in, c_reg<=cin, bit counter<=0, result shift register<=0; go to RUN.
  - start=0: remain in IDLE.
- RUN (edges k+1 .. k+WIDTH, one bit per edge):
  - Full-adder cell inputs: A=a_sh[0], B=b_sh[0], C=c_reg.
  - a_sh and b_sh shift right by one, zero fill.
  - Result shift register shifts right with S entering at bit WIDTH-1.
  - c_reg<=COUT; counter increments.
  - On the edge that processes bit WIDTH-1 (counter==WIDTH-1): sum<=final shifted result (S included), cout<=COUT; go to DONE.
- DONE:
  - done=1 for exactly one cycle, the cycle following edge k+WIDTH.
  - Unconditionally go to IDLE at the next edge.
- Latency: start sampled at edge k -> done high between edges k+WIDTH and k+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 edges: k, then the next accepted start at k+WIDTH+2, the first edge in IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are decoded from registered state, glitch-free.
- sum and cout update only on entry to DONE and hold until the next result or reset. Partial results are never visible on sum.
- start while in RUN or DONE is ignored, with no queuing.
  - a_in, b_in and cin may change freely after the accepting edge.
- Reset mid-RUN aborts the operation: no done pulse, sum and cout forced to 0.
- Counter width: clog2(WIDTH)+1 bits minimum. No wrap occurs, since the counter is reloaded on every accepted start.

Test Plan:
1. WIDTH=8, reset, then start with a_in=0x5A, b_in=0x33, cin=0 -> busy high 8 cycles; done pulse exactly at edge+9 cycle; sum=0x8D, cout=0.
2. a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum=0xFF, cout=1. Carry propagates through all bits.
3. Start with 0x12+0x34. Pulse start again with 0xFF+0xFF during RUN and again in DONE -> single done; sum=0x46, cout=0; no second operation.
4. Start with 0x0F+0x01. Assert rst asynchronously (mid-cycle) after 4 RUN edges -> busy=0, sum=0x00 immediately. No done afterwards. A fresh 0x0F+0x01 gives sum=0x10.
5. Back-to-back: start 0x01+0x02, then hold start=1 continuously -> second accepted at the first IDLE edge after done. Results are 0x03, then the new operands; done pulses spaced 10 cycles apart.
6. Exhaustive check with WIDTH=4: all 512 (a, b, cin) combinations -> {cout,sum}==a+b+cin for each. sum holds its value between operations.
